// File: rtl/pattern_scan_ctrl_if.sv
// Word-source handshake for pattern_scan_ctrl: valid/ready with a parallel data word.
interface pattern_scan_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Serialises accepted words MSB first into a programmable pattern detector and
// keeps per-word and saturating running match counts.
module pattern_scan_ctrl #(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       PAT_W   = 8,
  parameter int unsigned       CNT_W   = 8,
  parameter logic [PAT_W-1:0]  DEF_PAT = PAT_W'('h13),
  parameter int unsigned       DEF_LEN = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_we,
  input  logic [PAT_W-1:0]      cfg_pattern,
  input  logic [$clog2(PAT_W):0] cfg_len,
  output logic                  cfg_busy,
  pattern_scan_ctrl_if.slave    in_if,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  match,
  output logic                  word_done,
  output logic [CNT_W-1:0]      word_matches,
  output logic [CNT_W-1:0]      total_matches,
  input  logic                  clr_total
);

  localparam int unsigned LEN_W = $clog2(PAT_W) + 1;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q;
  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [PAT_W-2:0]   hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [DATA_W-1:0]  shreg_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   word_cnt_q;
  logic [CNT_W-1:0]   word_matches_q;
  logic [CNT_W-1:0]   total_q;

  logic [LEN_W-1:0]   len_eff;
  logic [PAT_W-1:0]   window;
  logic [PAT_W-1:0]   mask;
  logic               fill_ok;

  assign bit_valid     = (state_q == StShift);
  assign bit_out       = bit_valid & shreg_q[DATA_W-1];
  assign word_done     = (state_q == StDone);
  assign cfg_busy      = (state_q != StIdle);
  assign in_if.in_ready = (state_q == StIdle) & ~cfg_we;
  assign word_matches  = word_matches_q;
  assign total_matches = total_q;

  // Window bit 0 is the bit on the wire now; higher bits are progressively older history.
  assign len_eff = (len_q > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_q;
  assign window  = {hist_q, bit_out};
  assign fill_ok = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_eff};

  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      mask[i] = (LEN_W'(i) < len_eff);
    end
  end

  assign match = bit_valid & (len_eff != '0) & fill_ok & (((window ^ pat_q) & mask) == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      pat_q          <= DEF_PAT;
      len_q          <= LEN_W'(DEF_LEN);
      hist_q         <= '0;
      fill_q         <= '0;
      shreg_q        <= '0;
      idx_q          <= '0;
      word_cnt_q     <= '0;
      word_matches_q <= '0;
      total_q        <= '0;
    end else begin
      // A coincident clear drops the match it lands on.
      if (clr_total) begin
        total_q <= '0;
      end else if (match && (total_q != '1)) begin
        total_q <= total_q + CNT_W'(1);
      end

      case (state_q)
        StIdle: begin
          if (cfg_we) begin
            pat_q  <= cfg_pattern;
            len_q  <= cfg_len;
            hist_q <= '0;
            fill_q <= '0;
          end else if (in_if.in_valid) begin
            shreg_q    <= in_if.in_data;
            idx_q      <= '0;
            word_cnt_q <= '0;
            state_q    <= StShift;
          end
        end
        StShift: begin
          shreg_q <= shreg_q << 1;
          hist_q  <= window[PAT_W-2:0];
          if (fill_q != LEN_W'(PAT_W)) begin
            fill_q <= fill_q + LEN_W'(1);
          end
          if (match) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
          end
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            // Loaded on entry to DONE so the count is visible alongside word_done.
            word_matches_q <= word_cnt_q + CNT_W'(match);
            state_q        <= StDone;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed and random stimulus for pattern_scan_ctrl, checked against a bit-history model.
module tb_pattern_scan_ctrl;
  localparam int DW = 8;
  localparam int PW = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [PW-1:0] cfg_pattern = '0;
  logic [3:0]    cfg_len = '0;
  logic          clr_total = 1'b0;
  logic          cfg_busy, bit_out, bit_valid, match, word_done;
  logic [CW-1:0] word_matches, total_matches;

  always #5 clk = ~clk;

  pattern_scan_ctrl_if #(.DATA_W(DW)) in_if ();

  pattern_scan_ctrl #(
    .DATA_W(DW), .PAT_W(PW), .CNT_W(CW), .DEF_PAT(8'h13), .DEF_LEN(5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_busy(cfg_busy), .in_if(in_if), .bit_out(bit_out),
    .bit_valid(bit_valid), .match(match), .word_done(word_done),
    .word_matches(word_matches), .total_matches(total_matches), .clr_total(clr_total)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: every serial bit since the last config write or reset.
  logic [PW-1:0] m_pat;
  int            m_len;
  logic          bits[$];
  int            m_total;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pat = 8'h13;
    m_len = 5;
    bits.delete();
    m_total = 0;
  endtask

  task automatic model_bit(input logic b, output logic hit);
    int l;
    int n;
    bits.push_back(b);
    if (bits.size() > 2 * PW) void'(bits.pop_front());
    l = (m_len > PW) ? PW : m_len;
    n = bits.size();
    hit = (l != 0) && (n >= l);
    if (hit) begin
      for (int k = 0; k < l; k++) begin
        if (bits[n - l + k] !== m_pat[l - 1 - k]) hit = 1'b0;
      end
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_ready", in_if.in_ready, 1);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_match", match, 0);
    chk("rst_word_done", word_done, 0);
    chk("rst_word_matches", word_matches, 0);
    chk("rst_total", total_matches, 0);
    chk("rst_busy", cfg_busy, 0);
  endtask

  // Config write in IDLE; optionally offer a word in the same cycle (must not be taken).
  task automatic do_cfg(input logic [PW-1:0] p, input int l, input logic with_word,
                        input logic [DW-1:0] wd);
    @(negedge clk);
    clr_total = 1'b0;
    cfg_we = 1'b1;
    cfg_pattern = p;
    cfg_len = 4'(l);
    in_if.in_valid = with_word;
    in_if.in_data = wd;
    #1;
    chk("cfg_ready_low", in_if.in_ready, 0);
    chk("cfg_busy_idle", cfg_busy, 0);
    @(posedge clk);
    m_pat = p;
    m_len = l;
    bits.delete();
  endtask

  // Sends one word; cfg_at/clr_at/rst_at pulse those inputs at that bit index (-1 = never).
  task automatic send_word(input logic [DW-1:0] d, input int cfg_at, input int clr_at,
                           input int rst_at);
    int   wcnt;
    logic e;
    @(negedge clk);
    cfg_we = 1'b0;
    clr_total = 1'b0;
    in_if.in_valid = 1'b1;
    in_if.in_data = d;
    #1;
    chk("idle_ready", in_if.in_ready, 1);
    chk("idle_busy", cfg_busy, 0);
    @(negedge clk);
    in_if.in_valid = 1'($urandom_range(0, 1));
    in_if.in_data = DW'($urandom);
    wcnt = 0;
    for (int i = 0; i < DW; i++) begin
      cfg_we = (i == cfg_at);
      if (i == cfg_at) begin
        cfg_pattern = PW'($urandom);
        cfg_len = 4'($urandom);
      end
      clr_total = (i == clr_at);
      if (i == rst_at) begin
        in_if.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      #1;
      model_bit(d[DW - 1 - i], e);
      chk("bit_valid", bit_valid, 1);
      chk("bit_out", bit_out, d[DW - 1 - i]);
      chk("match", match, e);
      chk("shift_word_done", word_done, 0);
      chk("shift_ready", in_if.in_ready, 0);
      chk("shift_busy", cfg_busy, 1);
      chk("shift_total", total_matches, m_total);
      if (e) wcnt++;
      if (clr_total) m_total = 0;
      else if (e && m_total < CMAX) m_total++;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    clr_total = 1'b0;
    in_if.in_valid = 1'b0;
    #1;
    chk("done_word_done", word_done, 1);
    chk("done_word_matches", word_matches, wcnt);
    chk("done_total", total_matches, m_total);
    chk("done_bit_valid", bit_valid, 0);
    chk("done_match", match, 0);
  endtask

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals();
    reset_n = 1'b1;

    // Default pattern 10011 inside 8'h99.
    send_word(8'h99, -1, -1, -1);
    chk("t1_wm", word_matches, 1);
    chk("t1_total", total_matches, 1);

    // Pattern straddling a word boundary.
    send_word(8'h09, -1, -1, -1);
    chk("t2_wm_first", word_matches, 0);
    send_word(8'h80, -1, -1, -1);
    chk("t2_wm_second", word_matches, 1);

    // Overlapping 101 matches.
    do_cfg(8'h05, 3, 1'b0, 8'h00);
    send_word(8'hAA, -1, -1, -1);
    chk("t3_wm", word_matches, 3);

    // Config beats a simultaneous word; config during SHIFT is ignored.
    do_cfg(8'h05, 3, 1'b1, 8'hAA);
    send_word(8'hAA, 2, -1, -1);
    chk("t4_wm_after_cfg", word_matches, 3);
    send_word(8'hAA, 0, -1, -1);
    chk("t4_wm_ignored_cfg", word_matches, 4);

    // Saturation, then clear coincident with a match at bit index 2.
    repeat (8) send_word(8'hAA, -1, -1, -1);
    chk("t5_saturated", total_matches, CMAX);
    send_word(8'hAA, -1, 2, -1);
    chk("t5_after_clear", total_matches, 2);

    // Asynchronous reset mid-word restores the default pattern.
    send_word(8'hAA, -1, -1, 4);
    send_word(8'h99, -1, -1, -1);
    chk("t6_wm", word_matches, 1);
    chk("t6_total", total_matches, 1);

    // Random configs, words, mid-word config attempts and clears.
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) begin
        do_cfg(PW'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                           : int'($urandom_range(1, 4)),
               1'($urandom_range(0, 1)), DW'($urandom));
      end
      send_word(DW'($urandom),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DW - 1)) : -1,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, DW - 1)) : -1,
                -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Controller that sequences parallel data words into a programmable serial pattern detector, bit by bit. It owns the detector's pattern and length configuration and raises a Mealy-style match pulse per serial bit. It also reports per-word and running match counts. It sits between a valid/ready word source and downstream logic that consumes match events and counts.

## Interface

**Parameters**
- DATA_W, default 8: input word width; number of serial bits per word.
- PAT_W, default 8: maximum pattern length.
- CNT_W, default 8: width of `word_matches` and `total_matches`.
- DEF_PAT, default 8'h13: pattern after reset.
- DEF_LEN, default 5: pattern length after reset. With DEF_PAT this gives serial pattern 1,0,0,1,1.

**Ports**
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- cfg_we, input, 1: configuration write strobe.
- cfg_pattern, input, PAT_W: pattern. Bit [len-1] is the first serial bit; bit [0] is the last.
- cfg_len, input, $clog2(PAT_W)+1: pattern length.
- cfg_busy, output, 1: high when not IDLE (configuration writes are ignored).
- in_valid, input, 1: input word valid.
- in_data, input, DATA_W: input word, shifted MSB first.
- in_ready, output, 1: word accept.
- bit_out, output, 1: current serial bit.
- bit_valid, output, 1: `bit_out` is valid.
- match, output, 1: combinational Mealy pulse; the current bit completes the pattern.
- word_done, output, 1: one-cycle pulse after the last bit of a word.
- word_matches, output, CNT_W: matches within the last completed word.
- total_matches, output, CNT_W: saturating running match count.
- clr_total, input, 1: synchronous clear of `total_matches`.

## Operation

**States:** IDLE, SHIFT, DONE.

**IDLE**
- `in_ready = ~cfg_we`.
- If `cfg_we` is high: load the pattern and length; clear the history register and fill count. Any word offered in the same cycle is not accepted.
- Else if `in_valid` is high: latch `in_data` into the shift register, set bit index 0, clear the per-word counter, go to SHIFT.

**SHIFT**
- `bit_valid = 1`; `bit_out` = shift register MSB.
- Each cycle, shift left and append `bit_out` to the history (last PAT_W bits).
- Fill count increments, saturating at PAT_W.
- After bit index DATA_W-1, go to DONE.

**DONE**
- `word_done = 1`.
- `word_matches` is loaded with the per-word count in this cycle and holds until the next DONE.
- Go to IDLE.

**Match rule**
- Let L = `cfg_len`.
- `match = bit_valid & (L != 0) & (fill count >= L-1) & ({history[L-2:0], bit_out} == pattern[L-1:0])`.
- For L = 1, compare `bit_out` with `pattern[0]` only.
- Overlapping matches count.
- History persists across words, so a pattern may span a word boundary. Only a configuration write or reset clears it.
- L = 0 disables matching. L > PAT_W is treated as PAT_W.

**Counters**
- On each `match`, the per-word counter and `total_matches` increment.
- `total_matches` saturates at all-ones.
- `clr_total` is accepted in any state. If it coincides with a match, the clear wins and that match is not counted in the total.

**Configuration outside IDLE:** `cfg_we` is ignored and has no effect.

## Timing

**Reset values:**
- State IDLE.
- `in_ready = 1`; `bit_out`, `bit_valid`, `match`, `word_done` = 0.
- `word_matches`, `total_matches` = 0; `cfg_busy = 0`.
- Pattern = DEF_PAT, length = DEF_LEN; history and fill count = 0.

**Latency and throughput**
- Accept in cycle T.
- Bits appear in T+1 … T+DATA_W, MSB first.
- `word_done` is high in T+DATA_W+1.
- The next accept is possible in T+DATA_W+2, giving one word per DATA_W+2 cycles.

**Handshake:** a word transfers only when `in_valid & in_ready` at a rising edge. `in_data` is don't-care otherwise.

**Match timing:** `match` is asserted in the same cycle as the completing `bit_out`. It is not registered.

**Reset mid-operation:** asynchronous return to reset values. The partial word and its counts are discarded.

## Test plan

1. **Default pattern, single word.** After reset, send 8'h99. `match` pulses only on the 5th bit cycle. At `word_done`, `word_matches = 1` and `total_matches = 1`.
2. **Cross-word match.** Send 8'h09, then 8'h80. The first word ends with `word_matches = 0`. `match` pulses on the first bit of the second word; that word ends with `word_matches = 1`.
3. **Overlap.** Configure pattern 3'b101, length 3, then send 8'hAA. `match` pulses on bit cycles 3, 5 and 7; `word_matches = 3`.
4. **Configuration priority and ignore.** `cfg_we` together with `in_valid` in IDLE: the configuration loads, `in_ready = 0`, and the word is taken next cycle. `cfg_we` during SHIFT: the pattern is unchanged and matching continues with the old pattern.
5. **Saturation and clear.** With CNT_W = 4, pattern 101 and 8 words of 8'hAA, `total_matches` stops at 15. Then `clr_total` coincident with a match gives `total_matches = 0`.
6. **Reset mid-word.** Assert `reset_n = 0` at bit 4 of a word. All outputs return to reset values and the pattern reverts to 10011. A new 8'h99 then gives `word_matches = 1`.
